octant_rom_arbiter: RTL
=======================

Name: octant_rom_arbiter

Overview:
Shares the dual-read-port octant ROM between NUM_REQ ray-traversal units. Each cycle it grants up to two pending lookups in round-robin order and maps them onto ROM ports 1 and 2. It captures the ROM data one cycle later and returns it to the owning requester with a fixed latency. Out-of-range addresses are trapped and answered with an error flag instead of being sent to the ROM.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ADDRESS_WIDTH, 32, ROM word address width
DATA_WIDTH, 32, ROM word width
ROM_DEPTH, 4306, number of valid ROM words; legal addresses are 0..ROM_DEPTH-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
req_valid  in  NUM_REQ  per-requester lookup request
req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed addresses; requester i occupies bits [i*AW +: AW]
req_ready  out  NUM_REQ  grant; a handshake occurs when req_valid[i] and req_ready[i] are both high
rsp_valid  out  NUM_REQ  one-cycle response pulse
rsp_data  out  NUM_REQ*DATA_WIDTH  packed response data, registered, held until the next response
rsp_err  out  NUM_REQ  address out of range; qualified by rsp_valid
rom_addr1, rom_addr2  out  ADDRESS_WIDTH  ROM port addresses
rom_ren1, rom_ren2  out  1  ROM read enables
rom_dout1, rom_dout2  in  DATA_WIDTH  ROM data, valid one cycle after the ren cycle

Behaviour:
- State per requester:
  - busy[i]: set on handshake, cleared in the cycle rsp_valid[i] is asserted.
  - Requester i is eligible only when req_valid[i]=1 and busy[i]=0.
- Grant (combinational):
  - Scan the eligible requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first eligible requester gets slot 1; the second gets slot 2.
  - req_ready is high only for granted requesters; at most 2 bits are set.
- Slot mapping:
  - In-range slot 1 drives rom_addr1 and rom_ren1=1; in-range slot 2 drives rom_addr2 and rom_ren2=1.
  - An unused slot, or one holding an out-of-range address, drives ren=0 and addr=0.
  - An out-of-range grant still consumes its slot.
- rr_ptr update:
  - On any grant, rr_ptr <= (index of the last granted requester + 1) mod NUM_REQ.
  - With no grant, rr_ptr is unchanged.
- Pipeline (handshake in cycle T):
  - T: ROM captures the address.
  - T+1: stage-1 registers hold {owner id, slot, err}; rom_doutN is read and registered into rsp_data[owner].
  - T+2: rsp_valid[owner]=1 and busy[owner] clears.
  - Fixed latency is 2 cycles from handshake to rsp_valid.
  - The earliest next handshake for the same requester is T+3. The requester may hold req_valid high throughout; ready stays low while busy.
- Error path: an out-of-range grant gives rsp_valid=1, rsp_err=1 and rsp_data=0 at T+2.
- ROM port sharing: the ROM updates both douts whenever either ren is high. The arbiter samples only ports it actually issued in T, and ignores the other port.
- Throughput: 2 lookups/cycle sustained, given at least 6 busy-free requesters (each is blocked for 3 cycles).
- Reset:
  - rst_n low clears immediately: busy=0, rr_ptr=0, stage-1 valid=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - req_ready and rom_ren* are forced to 0 while rst_n is low.
  - In-flight lookups during reset are dropped; no rsp_valid is produced for them after release.
- Simultaneous events: a response to i and a new request from i in the same cycle is not a grant, because busy[i] is still 1 in that cycle.

Test Plan:
- Single lookup: req0 addr=5 in cycle 0 -> req_ready[0]=1 in cycle 0, rom_ren1=1 and rom_addr1=5; rsp_valid[0]=1 in cycle 2 with rsp_data=rom[5] and rsp_err=0; next grant no earlier than cycle 3.
- Four requesters held valid continuously (addr=i), rr_ptr=0 -> cycle 0 grants 0,1 (ports 1,2); cycle 1 grants 2,3; cycle 2 no grant; cycle 3 grants 0,1. Each response returns the correct rom[i].
- Fairness: req1 and req3 always valid, rr_ptr=2 -> first grant order 3 then 1 (slot1=3, slot2=1). rr_ptr becomes 2; no requester is starved over 100 cycles.
- Out-of-range: req2 addr=4306 alongside req0 addr=10 -> rom_ren for req2's slot stays 0; rsp_valid[2] at T+2 with rsp_err=1 and rsp_data=0; req0 gets rom[10].
- Reset mid-flight: grant req0 and req1, pull rst_n low at T+1 -> all outputs are 0 immediately; after release no rsp_valid appears, and a new request to req0 gets its grant with rr_ptr=0.
- Mixed ports: only slot 2 is out-of-range while slot 1 is valid -> rom_ren1=1 and rom_ren2=0; the slot 1 response data comes from rom_dout1 only.

Source files
------------

// File: rtl/octant_rom_arbiter.sv
// Round-robin arbiter sharing a dual-read-port octant ROM between NUM_REQ requesters.
// Grants up to two lookups per cycle and returns data or an out-of-range error two cycles later.
module octant_rom_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ROM_DEPTH     = 4306
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_addr,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]     rsp_data,
  output logic [NUM_REQ-1:0]                rsp_err,
  output logic [ADDRESS_WIDTH-1:0]          rom_addr1,
  output logic [ADDRESS_WIDTH-1:0]          rom_addr2,
  output logic                              rom_ren1,
  output logic                              rom_ren2,
  input  logic [DATA_WIDTH-1:0]             rom_dout1,
  input  logic [DATA_WIDTH-1:0]             rom_dout2
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW:0] NUM_REQ_W = (PW+1)'(NUM_REQ);
  localparam logic [ADDRESS_WIDTH-1:0] DEPTH_W = ADDRESS_WIDTH'(ROM_DEPTH);

  logic [NUM_REQ-1:0]       busy_q, busy_d;
  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic                     s1_valid1_q, s1_valid1_d, s1_valid2_q, s1_valid2_d;
  logic [PW-1:0]            s1_id1_q, s1_id1_d, s1_id2_q, s1_id2_d;
  logic                     s1_err1_q, s1_err1_d, s1_err2_q, s1_err2_d;
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]       rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q [NUM_REQ];
  logic [DATA_WIDTH-1:0]    rsp_data_d [NUM_REQ];

  logic [ADDRESS_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0]       eligible, grant;
  logic                     slot1_found, slot2_found, slot1_ok, slot2_ok;
  logic [PW-1:0]            slot1_id, slot2_id, last_id;
  logic [ADDRESS_WIDTH-1:0] slot1_addr, slot2_addr;
  logic [PW:0]              scan_idx, next_ptr;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    end
  end

  assign eligible = req_valid & ~busy_q;

  // Walk the eligible set starting at rr_ptr; the first two hits become slots 1 and 2.
  always_comb begin
    slot1_found = 1'b0;
    slot2_found = 1'b0;
    slot1_id    = '0;
    slot2_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (scan_idx >= NUM_REQ_W) scan_idx = scan_idx - NUM_REQ_W;
      if (eligible[scan_idx[PW-1:0]]) begin
        if (!slot1_found) begin
          slot1_found = 1'b1;
          slot1_id    = scan_idx[PW-1:0];
        end else if (!slot2_found) begin
          slot2_found = 1'b1;
          slot2_id    = scan_idx[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = (slot1_found && slot1_id == PW'(i)) || (slot2_found && slot2_id == PW'(i));
    end
  end

  assign slot1_addr = addr_arr[slot1_id];
  assign slot2_addr = addr_arr[slot2_id];
  assign slot1_ok   = slot1_addr < DEPTH_W;
  assign slot2_ok   = slot2_addr < DEPTH_W;

  // Out-of-range grants still own their slot but never reach the ROM.
  assign req_ready = rst_n ? grant : '0;
  assign rom_ren1  = rst_n & slot1_found & slot1_ok;
  assign rom_ren2  = rst_n & slot2_found & slot2_ok;
  assign rom_addr1 = rom_ren1 ? slot1_addr : '0;
  assign rom_addr2 = rom_ren2 ? slot2_addr : '0;

  always_comb begin
    last_id  = slot2_found ? slot2_id : slot1_id;
    next_ptr = {1'b0, last_id} + (PW+1)'(1);
    if (next_ptr >= NUM_REQ_W) next_ptr = '0;
    rr_ptr_d = slot1_found ? next_ptr[PW-1:0] : rr_ptr_q;
    busy_d   = (busy_q & ~rsp_valid_q) | grant;
    s1_valid1_d = slot1_found;
    s1_id1_d    = slot1_id;
    s1_err1_d   = ~slot1_ok;
    s1_valid2_d = slot2_found;
    s1_id2_d    = slot2_id;
    s1_err2_d   = ~slot2_ok;
  end

  // Each slot reads only its own ROM port; the other port's dout is ignored.
  always_comb begin
    rsp_valid_d = '0;
    rsp_err_d   = rsp_err_q;
    for (int i = 0; i < NUM_REQ; i++) rsp_data_d[i] = rsp_data_q[i];
    if (s1_valid1_q) begin
      rsp_valid_d[s1_id1_q] = 1'b1;
      rsp_err_d[s1_id1_q]   = s1_err1_q;
      rsp_data_d[s1_id1_q]  = s1_err1_q ? '0 : rom_dout1;
    end
    if (s1_valid2_q) begin
      rsp_valid_d[s1_id2_q] = 1'b1;
      rsp_err_d[s1_id2_q]   = s1_err2_q;
      rsp_data_d[s1_id2_q]  = s1_err2_q ? '0 : rom_dout2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      rr_ptr_q    <= '0;
      s1_valid1_q <= 1'b0;
      s1_id1_q    <= '0;
      s1_err1_q   <= 1'b0;
      s1_valid2_q <= 1'b0;
      s1_id2_q    <= '0;
      s1_err2_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) rsp_data_q[i] <= '0;
    end else begin
      busy_q      <= busy_d;
      rr_ptr_q    <= rr_ptr_d;
      s1_valid1_q <= s1_valid1_d;
      s1_id1_q    <= s1_id1_d;
      s1_err1_q   <= s1_err1_d;
      s1_valid2_q <= s1_valid2_d;
      s1_id2_q    <= s1_id2_d;
      s1_err2_q   <= s1_err2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      for (int i = 0; i < NUM_REQ; i++) rsp_data_q[i] <= rsp_data_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = rsp_data_q[i];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule
